// File: rtl/bist_pkg.sv
// Shared BIST types and default constants, used by the controller and the LFSR/MISR datapath.
package bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_FLUSH,
    S_COMPARE,
    S_DONE
  } bist_state_t;

  localparam logic [15:0] DEFAULT_SEED       = 16'hACE1;
  localparam logic [15:0] DEFAULT_GOLDEN_SIG = 16'h0000;

  // Counter width that still holds n; never narrower than one bit so n=0 stays legal.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bist_cycle_counter.sv
// Loadable down-counter; 'last' flags the final cycle of a loaded span of length load_val.
module bist_cycle_counter
  import bist_pkg::*;
#(
  parameter int MAX = 1,
  parameter int W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         last
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   count <= '0;
    else if (load)              count <= load_val;
    else if (en && count != '0) count <= count - 1'b1;
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/bist_ctrl.sv
// BIST sequencer: seeds the LFSR, runs PATTERN_COUNT patterns, flushes the CUT, checks the MISR.
// Optional BIST_CTRL_SIG_OUT_EN adds a sig_out port holding the signature captured at compare.
module bist_ctrl
  import bist_pkg::*;
#(
  parameter int               WIDTH         = 16,
  parameter int               PATTERN_COUNT = 255,
  parameter int               CUT_LATENCY   = 2,
  parameter logic [WIDTH-1:0] SEED          = DEFAULT_SEED,
  parameter logic [WIDTH-1:0] GOLDEN_SIG    = DEFAULT_GOLDEN_SIG,
  localparam int              CW            = $clog2(PATTERN_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] misr_sig,
  output logic             lfsr_load,
  output logic [WIDTH-1:0] lfsr_seed,
  output logic             lfsr_en,
  output logic             misr_clr,
  output logic             misr_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    pattern_cnt
`ifdef BIST_CTRL_SIG_OUT_EN
  ,
  output logic [WIDTH-1:0] sig_out
`endif
);

  localparam int RW = cnt_width(PATTERN_COUNT);
  localparam int FW = cnt_width(CUT_LATENCY);

  bist_state_t state, next;
  logic        run_last, flush_last;
  logic        kill;

  assign lfsr_seed = SEED;
  assign kill      = abort && busy;

  // Both spans are loaded during SEED; each only counts in its own state.
  bist_cycle_counter #(.MAX(PATTERN_COUNT), .W(RW)) u_run_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state == S_SEED),
    .load_val (RW'(PATTERN_COUNT)),
    .en       (state == S_RUN),
    .last     (run_last)
  );

  bist_cycle_counter #(.MAX(CUT_LATENCY), .W(FW)) u_flush_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state == S_SEED),
    .load_val (FW'(CUT_LATENCY)),
    .en       (state == S_FLUSH),
    .last     (flush_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE, S_DONE: if (start && !abort) next = S_SEED;
      S_SEED:         next = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort)         next = S_IDLE;
        else if (run_last) next = (CUT_LATENCY == 0) ? S_COMPARE : S_FLUSH;
      end
      S_FLUSH: begin
        if (abort)           next = S_IDLE;
        else if (flush_last) next = S_COMPARE;
      end
      S_COMPARE:      next = abort ? S_IDLE : S_DONE;
      default:        next = S_IDLE;
    endcase
  end

  always_comb begin
    lfsr_load = 1'b0;
    misr_clr  = 1'b0;
    lfsr_en   = 1'b0;
    misr_en   = 1'b0;
    busy      = 1'b0;
    unique case (state)
      S_SEED:    begin lfsr_load = 1'b1; misr_clr = 1'b1; busy = 1'b1; end
      S_RUN:     begin lfsr_en = 1'b1; misr_en = 1'b1; busy = 1'b1; end
      S_FLUSH:   begin misr_en = 1'b1; busy = 1'b1; end
      S_COMPARE: busy = 1'b1;
      default: ;
    endcase
  end

  // Result flags clear on entry to SEED so they never overlap busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done        <= 1'b0;
      pass        <= 1'b0;
      pattern_cnt <= '0;
    end else if (next == S_SEED) begin
      done        <= 1'b0;
      pass        <= 1'b0;
      pattern_cnt <= '0;
    end else if (kill) begin
      done <= 1'b0;
      pass <= 1'b0;
    end else if (state == S_COMPARE) begin
      done <= 1'b1;
      pass <= (misr_sig == GOLDEN_SIG);
    end else if (state == S_RUN && pattern_cnt != CW'(PATTERN_COUNT)) begin
      pattern_cnt <= pattern_cnt + 1'b1;
    end
  end

`ifdef BIST_CTRL_SIG_OUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  sig_out <= '0;
    else if (next == S_SEED || kill)           sig_out <= '0;
    else if (state == S_COMPARE)               sig_out <= misr_sig;
  end
`endif

endmodule

// File: tb/tb_bist_ctrl.sv
// Bench for bist_ctrl: behavioural LFSR/CUT/MISR around two instances (CUT_LATENCY 2 and 0).
module tb_bist_ctrl;
  import bist_pkg::*;

  localparam int PC = 8;
  localparam int CW = $clog2(PC + 1);

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction
  function automatic logic [15:0] mstep(input logic [15:0] m);
    return {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000);
  endfunction
  function automatic logic [15:0] cutf(input logic [15:0] x);
    return x ^ {x[7:0], x[15:8]} ^ 16'h5A5A;
  endfunction

  // Cycle-accurate signature of the datapath below; lat is 0 or 2.
  function automatic logic [15:0] golden(input int pc, input int lat);
    logic [15:0] l, m, p0, p1, cut;
    l = 16'hACE1; m = '0; p0 = '0; p1 = '0;
    for (int j = 1; j <= pc + lat; j++) begin
      cut = (lat == 0) ? cutf(l) : p1;
      m   = mstep(m) ^ cut;
      p1  = p0;
      p0  = cutf(l);
      if (j <= pc) l = lstep(l);
    end
    return m;
  endfunction

  localparam logic [15:0] GOLD_A = golden(PC, 2);
  localparam logic [15:0] GOLD_B = golden(PC, 0);

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic a_start = 1'b0, a_abort = 1'b0, b_start = 1'b0, b_abort = 1'b0, force_bad = 1'b0;
  logic [15:0] a_lfsr, a_s0, a_s1, a_misr, a_misr_in, b_lfsr, b_misr;
  logic a_load, a_len, a_clr, a_men, a_busy, a_done, a_pass;
  logic b_load, b_len, b_clr, b_men, b_busy, b_done, b_pass;
  logic [15:0] a_seed, b_seed;
  logic [CW-1:0] a_cnt, b_cnt;
`ifdef BIST_CTRL_SIG_OUT_EN
  logic [15:0] a_sig, b_sig;
`endif

  assign a_misr_in = force_bad ? 16'hDEAD : a_misr;

  always_ff @(posedge clk) begin
    if (a_load) a_lfsr <= a_seed;
    else if (a_len) a_lfsr <= lstep(a_lfsr);
    if (a_load) begin a_s0 <= '0; a_s1 <= '0; end
    else begin a_s0 <= cutf(a_lfsr); a_s1 <= a_s0; end
    if (a_clr) a_misr <= '0;
    else if (a_men) a_misr <= mstep(a_misr) ^ a_s1;
    if (b_load) b_lfsr <= b_seed;
    else if (b_len) b_lfsr <= lstep(b_lfsr);
    if (b_clr) b_misr <= '0;
    else if (b_men) b_misr <= mstep(b_misr) ^ cutf(b_lfsr);
  end

  bist_ctrl #(.WIDTH(16), .PATTERN_COUNT(PC), .CUT_LATENCY(2), .SEED(16'hACE1), .GOLDEN_SIG(GOLD_A)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .misr_sig(a_misr_in),
    .lfsr_load(a_load), .lfsr_seed(a_seed), .lfsr_en(a_len), .misr_clr(a_clr), .misr_en(a_men),
    .busy(a_busy), .done(a_done), .pass(a_pass), .pattern_cnt(a_cnt)
`ifdef BIST_CTRL_SIG_OUT_EN
    , .sig_out(a_sig)
`endif
  );

  bist_ctrl #(.WIDTH(16), .PATTERN_COUNT(PC), .CUT_LATENCY(0), .SEED(16'hACE1), .GOLDEN_SIG(GOLD_B)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .misr_sig(b_misr),
    .lfsr_load(b_load), .lfsr_seed(b_seed), .lfsr_en(b_len), .misr_clr(b_clr), .misr_en(b_men),
    .busy(b_busy), .done(b_done), .pass(b_pass), .pattern_cnt(b_cnt)
`ifdef BIST_CTRL_SIG_OUT_EN
    , .sig_out(b_sig)
`endif
  );

  typedef struct {int load, len, clr, men, busy, done, pass, cnt;} obs_t;
  typedef struct {int edges, n_load, n_clr, n_len, n_men, n_flush, n_busy, pass, cnt;} exp_t;

  exp_t sb[$];
  int compared = 0, mism = 0;

  function automatic obs_t obs(input bit sel);
    obs_t o;
    if (sel) begin
      o.load = int'(b_load); o.len = int'(b_len); o.clr = int'(b_clr); o.men = int'(b_men);
      o.busy = int'(b_busy); o.done = int'(b_done); o.pass = int'(b_pass); o.cnt = int'(b_cnt);
    end else begin
      o.load = int'(a_load); o.len = int'(a_len); o.clr = int'(a_clr); o.men = int'(a_men);
      o.busy = int'(a_busy); o.done = int'(a_done); o.pass = int'(a_pass); o.cnt = int'(a_cnt);
    end
    return o;
  endfunction

  task automatic chk(input string tag, input int ob, input int ex);
    compared++;
    assert (ob === ex) else begin
      mism++;
      $error("FAIL %s: observed %0d expected %0d", tag, ob, ex);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) b_start = v; else a_start = v;
  endtask

  task automatic chk_idle(input bit sel, input string tag, input int cnt);
    obs_t o;
    o = obs(sel);
    chk({tag, "_strobes"}, o.load | o.len | o.clr | o.men, 0);
    chk({tag, "_busy"}, o.busy, 0);
    chk({tag, "_done"}, o.done, 0);
    chk({tag, "_pass"}, o.pass, 0);
    chk({tag, "_cnt"}, o.cnt, cnt);
  endtask

  // One full run; expectations are queued at start and retired when done rises.
  task automatic run(input bit sel, input bit bad, input bit hold, input string tag);
    exp_t e, r;
    obs_t o;
    int lat, n_load, n_clr, n_len, n_men, n_flush, n_busy, edges, got;
    lat = sel ? 0 : 2;
    e.edges = PC + 2 + lat; e.n_load = 1; e.n_clr = 1; e.n_len = PC; e.n_men = PC + lat;
    e.n_flush = lat; e.n_busy = PC + 2 + lat; e.pass = bad ? 0 : 1; e.cnt = PC;
    sb.push_back(e);
    set_start(sel, 1'b1);
    tick();
    if (!hold) set_start(sel, 1'b0);
    o = obs(sel);
    chk({tag, "_seed_done"}, o.done, 0);
    chk({tag, "_seed_pass"}, o.pass, 0);
    chk({tag, "_seed_cnt"}, o.cnt, 0);
    n_load = 0; n_clr = 0; n_len = 0; n_men = 0; n_flush = 0; n_busy = 0; edges = -1; got = 0;
    for (int c = 0; c < 100; c++) begin
      o = obs(sel);
      if (o.done == 1) begin got = 1; edges = c; break; end
      n_load += o.load; n_clr += o.clr; n_len += o.len; n_men += o.men;
      n_flush += (o.men == 1 && o.len == 0) ? 1 : 0;
      n_busy += o.busy;
      if (bad && !sel && c == PC + 1 + lat) force_bad = 1'b1;
      tick();
      force_bad = 1'b0;
    end
    chk({tag, "_done_seen"}, got, 1);
    r = sb.pop_front();
    chk({tag, "_edges"}, edges, r.edges);
    chk({tag, "_n_load"}, n_load, r.n_load);
    chk({tag, "_n_clr"}, n_clr, r.n_clr);
    chk({tag, "_n_lfsr_en"}, n_len, r.n_len);
    chk({tag, "_n_misr_en"}, n_men, r.n_men);
    chk({tag, "_n_flush"}, n_flush, r.n_flush);
    chk({tag, "_n_busy"}, n_busy, r.n_busy);
    chk({tag, "_pass"}, o.pass, r.pass);
    chk({tag, "_cnt"}, o.cnt, r.cnt);
    chk({tag, "_busy_at_done"}, o.busy, 0);
  endtask

  initial begin
    obs_t o;
    int found;
    #2 rst = 1'b0;
    #1;
    chk_idle(0, "reset_a", 0);
    chk_idle(1, "reset_b", 0);
    @(posedge clk); #1 rst = 1'b1;
    tick();

    run(0, 1'b0, 1'b0, "nominal");
    run(0, 1'b1, 1'b0, "bad_sig");
`ifdef BIST_CTRL_SIG_OUT_EN
    chk("sig_out_bad", int'(a_sig), 32'h0000DEAD);
`endif

    // Abort while pattern_cnt reads 4 in RUN.
    a_start = 1'b1; tick(); a_start = 1'b0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (a_cnt == CW'(4)) begin found = 1; break; end
      tick();
    end
    chk("abort_reach_4", found, 1);
    a_abort = 1'b1; tick(); a_abort = 1'b0;
    chk_idle(0, "abort", 4);
`ifdef BIST_CTRL_SIG_OUT_EN
    chk("sig_out_abort", int'(a_sig), 0);
`endif
    tick();
    chk_idle(0, "abort_hold", 4);
    run(0, 1'b0, 1'b0, "post_abort");

    run(0, 1'b0, 1'b1, "held_1");
    run(0, 1'b0, 1'b0, "held_2");

    run(1, 1'b0, 1'b0, "lat0");

    // Asynchronous reset mid-RUN.
    a_start = 1'b1; tick(); a_start = 1'b0;
    tick(); tick(); tick();
    o = obs(0);
    chk("pre_reset_running", o.len, 1);
    #2 rst = 1'b0;
    #1;
    chk_idle(0, "async_reset", 0);
    @(posedge clk); #1 rst = 1'b1;
    tick();
    chk_idle(0, "after_reset", 0);
    run(0, 1'b0, 1'b0, "after_reset_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
